stopwatch_display: RTL and testbench

Downstream display stage for the 4-digit BCD stopwatch. It takes the 16-bit count `Q[1:16]` and the run level `ON_OFF` and drives a common-anode, time-multiplexed 4-digit 7-segment display. It snapshots the count once per scan frame so digits never tear, blanks a leading zero, and blinks the whole display while the stopwatch is paused.

---
 rtl/stopwatch_display.sv | 115 +++++++++++
 tb/tb_stopwatch_display.sv | 117 +++++++++++
 2 files changed

// File: rtl/stopwatch_display.sv
// Multiplexed 4-digit common-anode 7-segment driver for the BCD stopwatch.
// Latches the count once per scan frame, blanks a leading zero and blinks while paused.
module stopwatch_display #(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned BLINK_DIV  = 64,
    parameter bit          BLANK_LEAD = 1'b1
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic [1:16] Q,
    input  logic        ON_OFF,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [3:0]  AN
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] pcnt_q;
    logic [1:0]    idx_q;
    logic [1:16]   snap_q;
    logic [FW-1:0] fcnt_q;
    logic          phase_q;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;
    logic [3:0]    digit;
    logic          tick, wrap, blank;

    assign tick = (pcnt_q == PW'(SCAN_DIV - 1));
    assign wrap = tick && (idx_q == 2'd3);

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            pcnt_q  <= '0;
            idx_q   <= 2'd0;
            snap_q  <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b1;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            pcnt_q <= tick ? '0 : pcnt_q + PW'(1);
            if (tick) begin
                idx_q <= idx_q + 2'd1;
            end
            // Whole-frame snapshot keeps all four digits from the same count.
            if (wrap) begin
                snap_q <= Q;
            end
            if (ON_OFF) begin
                fcnt_q  <= '0;
                phase_q <= 1'b1;
            end else if (wrap) begin
                if (fcnt_q == FW'(BLINK_DIV - 1)) begin
                    fcnt_q  <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    fcnt_q <= fcnt_q + FW'(1);
                end
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    always_comb begin
        digit = 4'd0;
        case (idx_q)
            2'd0:    digit = snap_q[1:4];
            2'd1:    digit = snap_q[5:8];
            2'd2:    digit = snap_q[9:12];
            default: digit = snap_q[13:16];
        endcase
    end

    assign blank = BLANK_LEAD && (idx_q == 2'd3) && (digit == 4'd0);

    always_comb begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (phase_q && !blank) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg_decode(digit);
            dp_d  = (idx_q != 2'd2);
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = dp_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed frame-by-frame checks of the stopwatch display driver (SCAN_DIV=4, BLINK_DIV=2).
// A second instance with the leading-zero blank disabled runs on the same stimulus.
module tb_stopwatch_display;

    logic        clk = 1'b0;
    logic        RESET = 1'b0;
    logic [1:16] q = '0;
    logic        on_off = 1'b1;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  an_a, an_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stopwatch_display #(.SCAN_DIV(4), .BLINK_DIV(2), .BLANK_LEAD(1'b1)) dut_a (
        .clk(clk), .RESET(RESET), .Q(q), .ON_OFF(on_off),
        .SEG(seg_a), .DP(dp_a), .AN(an_a)
    );

    stopwatch_display #(.SCAN_DIV(4), .BLINK_DIV(2), .BLANK_LEAD(1'b0)) dut_b (
        .clk(clk), .RESET(RESET), .Q(q), .ON_OFF(on_off),
        .SEG(seg_b), .DP(dp_b), .AN(an_b)
    );

    // q/run are driven during the frame (shown next frame); an/seg are this frame's slots 0..3.
    typedef struct packed {
        logic [15:0] q;
        logic        run;
        logic        blank3;
        logic [15:0] an;
        logic [27:0] seg;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = {16'h4521, 1'b1, 1'b1, 16'hEDBF, 7'h40, 7'h40, 7'h40, 7'h7F};
        vecs[1] = {16'h7521, 1'b1, 1'b0, 16'hEDB7, 7'h19, 7'h12, 7'h24, 7'h79};
        vecs[2] = {16'h3A90, 1'b1, 1'b0, 16'hEDB7, 7'h78, 7'h12, 7'h24, 7'h79};
        vecs[3] = {16'h8600, 1'b0, 1'b1, 16'hEDBF, 7'h30, 7'h3F, 7'h10, 7'h7F};
        vecs[4] = {16'h8600, 1'b0, 1'b1, 16'hEDBF, 7'h00, 7'h02, 7'h40, 7'h7F};
        vecs[5] = {16'h9876, 1'b0, 1'b0, 16'hFFFF, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        vecs[6] = {16'h9876, 1'b0, 1'b0, 16'hFFFF, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        vecs[7] = {16'h9876, 1'b0, 1'b0, 16'hEDB7, 7'h10, 7'h00, 7'h78, 7'h02};
        vecs[8] = {16'h9876, 1'b0, 1'b0, 16'hEDB7, 7'h10, 7'h00, 7'h78, 7'h02};
        vecs[9] = {16'h9876, 1'b0, 1'b0, 16'hFFFF, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

        repeat (3) @(negedge clk);
        check("rst_an", {4'h0, an_a}, 8'h0F);
        check("rst_seg", {1'b0, seg_a}, 8'h7F);
        check("rst_dp", {7'h0, dp_a}, 8'h01);
        RESET = 1'b1;

        for (int v = 0; v < 10; v++) begin
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 4; c++) begin
                    logic [3:0] e_an, eb_an;
                    logic [6:0] e_seg, eb_seg;
                    logic       e_dp;
                    @(negedge clk);
                    if (s == 1 && c == 0) begin
                        q      = vecs[v].q;
                        on_off = vecs[v].run;
                    end
                    e_an   = vecs[v].an[(3-s)*4 +: 4];
                    e_seg  = vecs[v].seg[(3-s)*7 +: 7];
                    e_dp   = !(s == 2 && e_an != 4'hF);
                    eb_an  = (vecs[v].blank3 && s == 3) ? 4'h7 : e_an;
                    eb_seg = (vecs[v].blank3 && s == 3) ? 7'h40 : e_seg;
                    check($sformatf("f%0d_s%0d_c%0d_an", v, s, c), {4'h0, an_a}, {4'h0, e_an});
                    check($sformatf("f%0d_s%0d_c%0d_seg", v, s, c), {1'b0, seg_a}, {1'b0, e_seg});
                    check($sformatf("f%0d_s%0d_c%0d_dp", v, s, c), {7'h0, dp_a}, {7'h0, e_dp});
                    check($sformatf("f%0d_s%0d_c%0d_an_nb", v, s, c), {4'h0, an_b},
                          {4'h0, eb_an});
                    check($sformatf("f%0d_s%0d_c%0d_seg_nb", v, s, c), {1'b0, seg_b},
                          {1'b0, eb_seg});
                end
            end
        end

        // Frame 10 is dark; resume during its slot 1 must re-light within 2 cycles.
        repeat (5) @(negedge clk);
        check("dark_before_resume", {4'h0, an_a}, 8'h0F);
        on_off = 1'b1;
        repeat (2) @(negedge clk);
        check("resume_an", {4'h0, an_a}, 8'h0D);
        check("resume_seg", {1'b0, seg_a}, 8'h00);

        // Asynchronous reset mid-slot: outputs clear without a clock edge.
        #2 RESET = 1'b0;
        #1;
        check("async_rst_an", {4'h0, an_a}, 8'h0F);
        check("async_rst_seg", {1'b0, seg_a}, 8'h7F);
        check("async_rst_dp", {7'h0, dp_a}, 8'h01);
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        check("post_rst_an", {4'h0, an_a}, 8'h0E);
        check("post_rst_seg", {1'b0, seg_a}, 8'h40);
        check("post_rst_dp", {7'h0, dp_a}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
